// File: rtl/bridge_driver.sv
`timescale 1ns/1ps
// H-bridge gate driver for the DRSSTC controller: dead-time insertion,
// osc-edge-aligned burst start/stop, burst length limit and latched overcurrent fault.
module bridge_driver #(
    parameter int CLK_MHZ      = 100,
    parameter int DEAD_TIME_NS = 100,
    parameter int MAX_ON_US    = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic osc,
    input  logic intr,
    input  logic ocd,
    input  logic fault_clr,
    output logic gate_a,
    output logic gate_b,
    output logic active,
    output logic fault
);

    localparam int DT    = (DEAD_TIME_NS * CLK_MHZ + 999) / 1000;
    localparam int MAXON = MAX_ON_US * CLK_MHZ;
    localparam int DW    = $clog2(DT + 1);
    localparam int OW    = $clog2(MAXON + 1);

    localparam logic [DW-1:0] DT_M1   = DW'(DT - 1);
    localparam logic [OW-1:0] MAXON_V = OW'(MAXON);

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        DRIVE,
        HOLD,
        FAULT
    } state_t;

    state_t        state;
    logic          osc_d;
    logic          ph;
    logic [DW-1:0] dcnt;
    logic [OW-1:0] ontime;
    logic          osc_edge;
    logic          expired;

    assign osc_edge = osc ^ osc_d;
    assign expired  = (ontime == MAXON_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            osc_d  <= 1'b0;
            ph     <= 1'b0;
            dcnt   <= '0;
            ontime <= '0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            active <= 1'b0;
            fault  <= 1'b0;
        end else begin
            osc_d <= osc;
            if (ocd) begin
                state  <= FAULT;
                gate_a <= 1'b0;
                gate_b <= 1'b0;
                active <= 1'b0;
                fault  <= 1'b1;
            end else begin
                // Burst time counts across both dead and drive intervals
                if ((state == DEAD || state == DRIVE) && !expired)
                    ontime <= ontime + 1'b1;
                case (state)
                    IDLE: begin
                        if (intr && osc_edge) begin
                            state  <= DEAD;
                            dcnt   <= DT_M1;
                            ph     <= osc;
                            ontime <= '0;
                            active <= 1'b1;
                        end
                    end
                    DEAD: begin
                        if (osc_edge) begin
                            dcnt <= DT_M1;
                            ph   <= osc;
                        end else if (dcnt == '0) begin
                            state  <= DRIVE;
                            gate_a <= ph;
                            gate_b <= ~ph;
                        end else begin
                            dcnt <= dcnt - 1'b1;
                        end
                    end
                    DRIVE: begin
                        if (osc_edge) begin
                            gate_a <= 1'b0;
                            gate_b <= 1'b0;
                            if (!intr) begin
                                state  <= IDLE;
                                active <= 1'b0;
                            end else if (expired) begin
                                state  <= HOLD;
                                active <= 1'b0;
                            end else begin
                                state <= DEAD;
                                dcnt  <= DT_M1;
                                ph    <= osc;
                            end
                        end
                    end
                    HOLD: begin
                        if (!intr)
                            state <= IDLE;
                    end
                    FAULT: begin
                        // ocd is known low here, so fault_clr alone releases
                        if (fault_clr) begin
                            state <= HOLD;
                            fault <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bridge_driver.sv
`timescale 1ns/1ps
// Directed bench for bridge_driver: default instance (DT=10, MAXON=20000)
// plus a short-limit instance (MAXON=200) sharing the same stimulus.
module tb_bridge_driver;

    logic clk = 1'b0;
    logic rst, osc, intr, ocd, fault_clr;
    logic ga, gb, act, flt;
    logic la, lb, lact, lflt;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;
    int hi_a    = 0;
    int hi_b    = 0;

    bridge_driver u_dut (
        .clk       (clk),
        .rst       (rst),
        .osc       (osc),
        .intr      (intr),
        .ocd       (ocd),
        .fault_clr (fault_clr),
        .gate_a    (ga),
        .gate_b    (gb),
        .active    (act),
        .fault     (flt)
    );

    bridge_driver #(.MAX_ON_US(2)) u_lim (
        .clk       (clk),
        .rst       (rst),
        .osc       (osc),
        .intr      (intr),
        .ocd       (ocd),
        .fault_clr (fault_clr),
        .gate_a    (la),
        .gate_b    (lb),
        .active    (lact),
        .fault     (lflt)
    );

    always #5 clk = ~clk;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ((ga & gb) | (la & lb))
                overlap++;
            if (ga)
                hi_a++;
            if (gb)
                hi_b++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        osc = 1'b0;
        intr = 1'b0;
        ocd = 1'b0;
        fault_clr = 1'b0;
        run(3);
        chk("rst_gate_a", ga, 0);
        chk("rst_gate_b", gb, 0);
        chk("rst_active", act, 0);
        chk("rst_fault", flt, 0);
        rst = 1'b0;
        run(2);

        // normal burst, half-period 125
        intr = 1'b1;
        run(5);
        chk("idle_no_edge", act, 0);
        osc = 1'b1;
        run(1);
        chk("start_active", act, 1);
        chk("start_dead_a", ga, 0);
        run(9);
        chk("dead_k10_a", ga, 0);
        run(1);
        chk("first_rise_a", ga, 1);
        chk("first_rise_b", gb, 0);
        run(114);
        chk("a_high_end", ga, 1);
        osc = 1'b0;
        run(1);
        chk("a_drop", ga, 0);
        chk("b_dead", gb, 0);
        run(10);
        chk("b_rise", gb, 1);
        run(114);
        chk("b_high_end", gb, 1);
        hi_a = 0;
        hi_b = 0;
        for (int i = 0; i < 6; i++) begin
            osc = ~osc;
            run(125);
        end
        chk("a_high_cycles", hi_a, 345);
        chk("b_high_cycles", hi_b, 345);

        // stop alignment
        osc = 1'b1;
        run(60);
        chk("stop_pre_a", ga, 1);
        intr = 1'b0;
        run(1);
        chk("stop_intr_low_a", ga, 1);
        run(64);
        chk("stop_hold_a", ga, 1);
        chk("stop_hold_act", act, 1);
        osc = 1'b0;
        run(1);
        chk("stop_a", ga, 0);
        chk("stop_b", gb, 0);
        chk("stop_act", act, 0);
        run(20);
        chk("stopped_b", gb, 0);
        chk("stopped_act", act, 0);

        // edge during dead time
        intr = 1'b1;
        osc = 1'b1;
        run(6);
        osc = 1'b0;
        run(5);
        chk("dt_edge_k11_a", ga, 0);
        chk("dt_edge_k11_b", gb, 0);
        run(5);
        chk("dt_edge_k16_b", gb, 0);
        chk("dt_edge_act", act, 1);
        run(1);
        chk("dt_edge_rise_b", gb, 1);
        chk("dt_edge_a", ga, 0);

        // overcurrent
        run(10);
        ocd = 1'b1;
        run(1);
        chk("ocd_b", gb, 0);
        chk("ocd_fault", flt, 1);
        chk("ocd_act", act, 0);
        ocd = 1'b0;
        osc = 1'b1;
        run(130);
        chk("fault_held", flt, 1);
        chk("fault_a", ga, 0);
        chk("fault_b", gb, 0);
        fault_clr = 1'b1;
        ocd = 1'b1;
        run(3);
        chk("clr_ignored", flt, 1);
        ocd = 1'b0;
        run(1);
        chk("clr_fault", flt, 0);
        chk("clr_act", act, 0);
        fault_clr = 1'b0;
        osc = 1'b0;
        run(15);
        chk("hold_act", act, 0);
        chk("hold_b", gb, 0);
        intr = 1'b0;
        run(2);
        intr = 1'b1;
        run(3);
        chk("rearm_no_edge", act, 0);
        osc = 1'b1;
        run(10);
        chk("rearm_dead_a", ga, 0);
        chk("rearm_act", act, 1);
        run(1);
        chk("rearm_rise_a", ga, 1);

        // reset mid-burst
        rst = 1'b1;
        run(1);
        chk("mid_rst_a", ga, 0);
        chk("mid_rst_b", gb, 0);
        chk("mid_rst_act", act, 0);
        chk("mid_rst_fault", flt, 0);
        osc = 1'b0;
        run(2);
        rst = 1'b0;
        run(20);
        chk("post_rst_idle", act, 0);
        osc = 1'b1;
        run(11);
        chk("post_rst_rise_a", ga, 1);

        // burst limit on the MAXON=200 instance
        rst = 1'b1;
        osc = 1'b0;
        run(2);
        rst = 1'b0;
        intr = 1'b1;
        run(3);
        osc = 1'b1;
        run(125);
        chk("lim_first_a", la, 1);
        osc = 1'b0;
        run(125);
        chk("lim_second_b", lb, 1);
        osc = 1'b1;
        run(1);
        chk("lim_stop_a", la, 0);
        chk("lim_stop_b", lb, 0);
        chk("lim_stop_act", lact, 0);
        chk("nolim_continues", act, 1);
        run(124);
        osc = 1'b0;
        run(20);
        chk("lim_hold_act", lact, 0);
        chk("lim_hold_b", lb, 0);
        intr = 1'b0;
        run(2);
        intr = 1'b1;
        run(3);
        chk("lim_rearm_no_edge", lact, 0);
        osc = 1'b1;
        run(11);
        chk("lim_restart_a", la, 1);
        chk("lim_restart_act", lact, 1);

        chk("no_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bridge_driver.md
# bridge_driver

Downstream stage of the `gen` oscillator in the DRSSTC controller. Converts the `gen` square wave `osc` into two non-overlapping H-bridge gate commands with programmable dead time. Bursts are gated by the interrupter request `intr`, and the block starts and stops only on `osc` edges. It enforces a maximum burst length and latches an overcurrent fault until it is explicitly cleared.

## Interface
- CLK_MHZ, 100, clock frequency in MHz; must match `gen`.
- DEAD_TIME_NS, 100, dead time. DT = ceil(DEAD_TIME_NS*CLK_MHZ/1000) cycles; DT ≥ 1 and DT < 125.
- MAX_ON_US, 200, maximum burst length. MAXON = MAX_ON_US*CLK_MHZ cycles.
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- osc  in  1  square wave from `gen.out`, synchronous to clk; no synchronizer needed.
- intr  in  1  interrupter burst request, level, synchronous.
- ocd  in  1  overcurrent detect, active high, synchronous.
- fault_clr  in  1  fault clear request, level.
- gate_a  out  1  high-side A / low-side B drive while osc phase = 1.
- gate_b  out  1  complementary leg, driven while osc phase = 0.
- active  out  1  high while a burst is running.
- fault  out  1  latched overcurrent indication.

## Operation
- All outputs are registered. Reset values: gate_a=0, gate_b=0, active=0, fault=0, state=IDLE, osc_d=0, counters=0.
- Edge detect: osc_d <= osc every cycle; `edge = osc ^ osc_d`; `phase = osc`.
- FSM states: IDLE, DEAD, DRIVE, HOLD, FAULT.
- Priority order: rst > ocd > state transitions.
- **IDLE:** gates are 0. When intr=1 and edge=1, go to DEAD with dcnt <= DT-1, ph <= phase, and ontime <= 0.
- **DEAD:** gates are 0. dcnt decrements each cycle. When dcnt==0, go to DRIVE with gate_a <= ph and gate_b <= ~ph.
  - An edge during DEAD reloads dcnt <= DT-1 and updates ph; both gates stay 0.
- **DRIVE:** gates hold the values set on entry. On edge:
  - If intr=1 and not expired, go to DEAD with the new phase and both gates 0.
  - If intr=0, go to IDLE with both gates 0.
  - If expired, go to HOLD with both gates 0.
  - With no edge, DRIVE holds regardless of intr. Stopping always happens at an osc transition.
- **ontime:** increments every cycle in DEAD or DRIVE and saturates at MAXON. expired = (ontime == MAXON).
- **HOLD:** gates are 0. Stay until intr=0, then go to IDLE. This prevents an immediate re-burst after a forced stop.
- **FAULT:** entered from any state when ocd=1. On that clock edge gates <= 0 and fault <= 1.
  - Exit requires fault_clr=1 and ocd=0 in the same cycle; the block then goes to HOLD with fault <= 0.
  - fault_clr while ocd=1 is ignored.
- active = 1 exactly in DEAD or DRIVE (registered with state).
- gate_a & gate_b == 1 must never occur, including across reset and fault.

## Timing
- osc toggles after clock edge k. The edge is detected at edge k+1, where the FSM enters DEAD and gates drop.
- The new gate rises at edge k+1+DT. Both gates are low for exactly DT cycles.
- Start latency: with intr already 1, the first gate rises DT+1 cycles after the first osc toggle.
- Stop latency: gates go to 0 at edge k+1 after the first osc toggle that follows intr falling. intr pulses shorter than the remaining half-period are still honoured as a full half-cycle.
- ocd to gates low: 1 cycle (registered).
- fault_clr to leaving FAULT: 1 cycle. The next burst needs intr=0 followed by intr=1 and an edge.
- Expiry check: expired is sampled at the osc edge. The final half-cycle may overrun MAXON by up to one half-period.
- rst asserted mid-burst: gates drop at the next edge; the block resumes in IDLE.

## Test plan
- **Normal burst:** defaults (DT=10), osc half-period 125, intr=1 for 1000 cycles.
  - gate_a and gate_b alternate, each high 115 cycles with 10-cycle gaps.
  - Never both high; first rise 11 cycles after the first osc toggle.
- **Stop alignment:** drop intr mid-half-cycle.
  - The gate stays high until the next osc toggle, goes low 1 cycle later; active=0 the same cycle.
- **Burst limit:** MAX_ON_US=2 (MAXON=200), intr held 1.
  - Gates stop at the first osc edge after ontime reaches 200; state is HOLD.
  - No restart until intr goes to 0 and back to 1.
- **Overcurrent:** ocd=1 for 1 cycle during DRIVE.
  - Gates are 0 and fault=1 on the next cycle, held indefinitely.
  - fault_clr with ocd=1 is ignored; fault_clr with ocd=0 clears fault one cycle later.
- **Edge during dead time:** DT=10, force an osc toggle 5 cycles into DEAD.
  - The dead counter restarts, gates stay 0 for 10 more cycles, then the opposite leg drives.
- **Reset mid-burst:** rst=1 during DRIVE.
  - All outputs are 0 at the next edge; after release, the burst restarts only on an osc edge with intr=1.
